// File: rtl/pipe_adder_nbit_if.sv
// Operand/result handshake bundle for the segmented pipelined adder.
// slave = adder side, master = producer/consumer side.
interface pipe_adder_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );
endinterface

// File: rtl/pipe_adder_nbit.sv
// Carry-segmented pipelined adder: one SEG-bit ripple segment per stage.
// Global stall on output backpressure; outputs come straight from flops.
module pipe_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_adder_nbit_if.slave bus
);
    localparam int NSTG = WIDTH / SEG;

    logic w_stall;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LOW = (k + 1) * SEG;
        localparam int HIW = WIDTH - LOW;

        logic [SEG-1:0] w_sa;
        logic [SEG-1:0] w_sb;
        logic [SEG-1:0] w_s;
        logic           w_ci;
        logic           w_co;
        logic           w_vin;
        logic [LOW-1:0] w_lo;

        logic           r_vld;
        logic [LOW-1:0] r_sum;
        logic           r_c;

        if (k == 0) begin : g_src
            assign w_sa  = bus.a[SEG-1:0];
            assign w_sb  = bus.b[SEG-1:0];
            assign w_ci  = bus.cin;
            assign w_vin = bus.in_valid;
            assign w_lo  = w_s;
        end else begin : g_src
            assign w_sa  = g_stg[k-1].g_op.r_ha[SEG-1:0];
            assign w_sb  = g_stg[k-1].g_op.r_hb[SEG-1:0];
            assign w_ci  = g_stg[k-1].r_c;
            assign w_vin = g_stg[k-1].r_vld;
            assign w_lo  = {w_s, g_stg[k-1].r_sum};
        end

        assign {w_co, w_s} = {1'b0, w_sa}
                           + {1'b0, w_sb}
                           + {{SEG{1'b0}}, w_ci};

        // Data only loads on a valid beat so the
        // output keeps its last result across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_sum <= '0;
                r_c   <= 1'b0;
            end else if (!w_stall) begin
                r_vld <= w_vin;
                if (w_vin) begin
                    r_sum <= w_lo;
                    r_c   <= w_co;
                end
            end
        end

        if (k < NSTG - 1) begin : g_op
            logic [HIW-1:0] w_ha;
            logic [HIW-1:0] w_hb;
            logic [HIW-1:0] r_ha;
            logic [HIW-1:0] r_hb;

            if (k == 0) begin : g_in
                assign w_ha = bus.a[WIDTH-1:SEG];
                assign w_hb = bus.b[WIDTH-1:SEG];
            end else begin : g_in
                assign w_ha =
                    g_stg[k-1].g_op.r_ha[HIW+SEG-1:SEG];
                assign w_hb =
                    g_stg[k-1].g_op.r_hb[HIW+SEG-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ha <= '0;
                    r_hb <= '0;
                end else if (!w_stall && w_vin) begin
                    r_ha <= w_ha;
                    r_hb <= w_hb;
                end
            end
        end else begin : g_tail
            logic w_cmsb;
            logic r_ovf;

            // Carry into the MSB recovered from its sum bit.
            assign w_cmsb = w_s[SEG-1] ^ w_sa[SEG-1]
                          ^ w_sb[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall && w_vin) begin
                    r_ovf <= w_cmsb ^ w_co;
                end
            end
        end
    end

    assign w_stall      = g_stg[NSTG-1].r_vld
                        && !bus.out_ready;
    assign bus.in_ready = !w_stall;

    assign bus.out_valid = g_stg[NSTG-1].r_vld;
    assign bus.sum       = g_stg[NSTG-1].r_sum;
    assign bus.cout      = g_stg[NSTG-1].r_c;
    assign bus.ovf       = g_stg[NSTG-1].g_tail.r_ovf;
endmodule
